// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_RTYPEEX,
        ST_RTYPEWB,
        ST_BEQEX,
        ST_BNEEX,
        ST_ADDIEX,
        ST_ADDIWB,
        ST_JEX
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps aluop and the R-type funct field to an ALU operation code,
// zero-extended into an ACW-bit alucontrol.
module aludec
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned FUNCTW = 6,
    parameter int unsigned ACW    = 3
) (
    input  logic [FUNCTW-1:0] funct,
    input  logic [1:0]        aluop,
    output logic [ACW-1:0]    alucontrol
);

    logic [2:0] code;

    always_comb begin
        code = ALU_ADD;
        case (aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCTW'(FUNCT_ADD): code = ALU_ADD;
                    FUNCTW'(FUNCT_SUB): code = ALU_SUB;
                    FUNCTW'(FUNCT_AND): code = ALU_AND;
                    FUNCTW'(FUNCT_OR):  code = ALU_OR;
                    FUNCTW'(FUNCT_SLT): code = ALU_SLT;
                    default:            code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alucontrol = ACW'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath; memory
// states hold until memready, branch/PC enables are qualified by zero.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPW     = 6,
    parameter int unsigned FUNCTW  = 6,
    parameter int unsigned ACW     = 3,
    parameter int unsigned NO_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    op,
    input  logic [FUNCTW-1:0] funct,
    input  logic              zero,
    input  logic              memready,
    output logic              memreq,
    output logic              memwrite,
    output logic              iord,
    output logic              irwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic              pcen,
    output logic [ACW-1:0]    alucontrol,
    output logic              illegal
);

    state_e     state_q, state_d;
    logic       ready;
    logic       memreq_c, memwrite_c, irwrite_c, regwrite_c, illegal_c;
    logic       pcwrite_c, branch_c, bne_c;
    logic [1:0] aluop_c;

    assign ready = (NO_WAIT != 0) ? 1'b1 : memready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        state_d    = state_q;
        memreq_c   = 1'b0;
        memwrite_c = 1'b0;
        iord       = 1'b0;
        irwrite_c  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_c = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUSRCB_B;
        pcsrc      = PCSRC_ALU;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        bne_c      = 1'b0;
        illegal_c  = 1'b0;
        aluop_c    = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                memreq_c  = 1'b1;
                alusrcb   = ALUSRCB_FOUR;
                pcsrc     = PCSRC_ALU;
                irwrite_c = ready;
                pcwrite_c = ready;
                if (ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alusrcb = ALUSRCB_IMMSH;
                case (op)
                    OPW'(OP_LW), OPW'(OP_SW): state_d = ST_MEMADR;
                    OPW'(OP_RTYPE):           state_d = ST_RTYPEEX;
                    OPW'(OP_BEQ):             state_d = ST_BEQEX;
                    OPW'(OP_BNE):             state_d = ST_BNEEX;
                    OPW'(OP_ADDI):            state_d = ST_ADDIEX;
                    OPW'(OP_J):               state_d = ST_JEX;
                    default: begin
                        state_d   = ST_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
                state_d = (op == OPW'(OP_LW)) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                memreq_c = 1'b1;
                iord     = 1'b1;
                if (ready) state_d = ST_MEMWB;
            end
            ST_MEMWR: begin
                memreq_c   = 1'b1;
                iord       = 1'b1;
                memwrite_c = 1'b1;
                if (ready) state_d = ST_FETCH;
            end
            ST_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_RTYPEEX: begin
                alusrca = 1'b1;
                aluop_c = ALUOP_FUNCT;
                state_d = ST_RTYPEWB;
            end
            ST_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BEQEX: begin
                alusrca  = 1'b1;
                aluop_c  = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                branch_c = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_BNEEX: begin
                alusrca = 1'b1;
                aluop_c = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                bne_c   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
                state_d = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_JEX: begin
                pcsrc     = PCSRC_JUMP;
                pcwrite_c = 1'b1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset suppresses every write strobe so an abandoned instruction has no side effects.
    assign memreq   = memreq_c   & ~reset;
    assign memwrite = memwrite_c & ~reset;
    assign irwrite  = irwrite_c  & ~reset;
    assign regwrite = regwrite_c & ~reset;
    assign illegal  = illegal_c  & ~reset;
    assign pcen     = (pcwrite_c | (branch_c & zero) | (bne_c & ~zero)) & ~reset;

    aludec #(
        .FUNCTW (FUNCTW),
        .ACW    (ACW)
    ) u_aludec (
        .funct      (funct),
        .aluop      (aluop_c),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full control word against hand-built values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       memreq, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memready   (memready),
        .memreq     (memreq),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    // {memreq,memwrite,iord,irwrite, regdst,memtoreg,regwrite,alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal}
    localparam logic [16:0] E_FETCH_RDY  = {4'b1001, 4'b0000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0};
    localparam logic [16:0] E_FETCH_WAIT = {4'b1000, 4'b0000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_DECODE     = {4'b0000, 4'b0000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_DECODE_ILL = {4'b0000, 4'b0000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b1};
    localparam logic [16:0] E_MEMADR     = {4'b0000, 4'b0001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_MEMRD      = {4'b1010, 4'b0000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_MEMWR      = {4'b1110, 4'b0000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_MEMWB      = {4'b0000, 4'b0110, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_RTYPE_SLT  = {4'b0000, 4'b0001, 2'b00, 2'b00, 1'b0, 3'b111, 1'b0};
    localparam logic [16:0] E_RTYPEWB    = {4'b0000, 4'b1010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_BR_TAKEN   = {4'b0000, 4'b0001, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0};
    localparam logic [16:0] E_BR_NOT     = {4'b0000, 4'b0001, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0};
    localparam logic [16:0] E_ADDIEX     = {4'b0000, 4'b0001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_ADDIWB     = {4'b0000, 4'b0010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_JEX        = {4'b0000, 4'b0000, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0};

    function automatic logic [16:0] ctrl_vec();
        return {memreq, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, illegal};
    endfunction

    function automatic logic [5:0] strobes();
        return {memreq, memwrite, irwrite, regwrite, pcen, illegal};
    endfunction

    task automatic test_reset();
        reset = 1'b1; memready = 1'b1; zero = 1'b1; op = 6'b100011; funct = 6'b0;
        @(posedge clk); #1;
        checks++;
        if (strobes() !== 6'b0) $display("FAIL reset_strobes: got %b expected %b", strobes(), 6'b0);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0; memready = 1'b0; #1;
        checks++;
        if (ctrl_vec() !== E_FETCH_WAIT) $display("FAIL reset_fetch: got %b expected %b", ctrl_vec(), E_FETCH_WAIT);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        logic [16:0] exp [0:5];
        exp = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH_WAIT};
        op = 6'b100011; zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            memready = (i == 5) ? 1'b0 : 1'b1; #1;
            checks++;
            if (ctrl_vec() !== exp[i]) $display("FAIL lw cycle %0d: got %b expected %b", i, ctrl_vec(), exp[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        logic [16:0] exp [0:6];
        logic        mr  [0:6];
        exp = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_FETCH_WAIT};
        mr  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        op = 6'b101011; zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            memready = mr[i]; #1;
            checks++;
            if (ctrl_vec() !== exp[i]) $display("FAIL sw_wait cycle %0d: got %b expected %b", i, ctrl_vec(), exp[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch(input logic [5:0] opc, input logic z, input logic [16:0] exp_ex, input string name);
        logic [16:0] exp [0:3];
        exp = '{E_FETCH_RDY, E_DECODE, exp_ex, E_FETCH_WAIT};
        op = opc; zero = z;
        for (int i = 0; i < 4; i++) begin
            memready = (i == 3) ? 1'b0 : 1'b1; #1;
            checks++;
            if (ctrl_vec() !== exp[i]) $display("FAIL %s cycle %0d: got %b expected %b", name, i, ctrl_vec(), exp[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [16:0] exp [0:4];
        logic [5:0]  fn  [0:5];
        logic [2:0]  ac  [0:5];
        exp = '{E_FETCH_RDY, E_DECODE, E_RTYPE_SLT, E_RTYPEWB, E_FETCH_WAIT};
        op = 6'b000000; funct = 6'b101010; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            memready = (i == 4) ? 1'b0 : 1'b1; #1;
            checks++;
            if (ctrl_vec() !== exp[i]) $display("FAIL rtype_slt cycle %0d: got %b expected %b", i, ctrl_vec(), exp[i]);
            else passed++;
            @(posedge clk); #1;
        end
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        ac = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
        for (int k = 0; k < 6; k++) begin
            funct = fn[k]; memready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++;
            if (alucontrol !== ac[k]) $display("FAIL rtype_funct %b: got %b expected %b", fn[k], alucontrol, ac[k]);
            else passed++;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        memready = 1'b0;
    endtask

    task automatic test_addi_fetch_wait();
        logic [16:0] exp [0:5];
        exp = '{E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH_WAIT};
        op = 6'b001000; zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            memready = (i == 0 || i == 5) ? 1'b0 : 1'b1; #1;
            checks++;
            if (ctrl_vec() !== exp[i]) $display("FAIL addi cycle %0d: got %b expected %b", i, ctrl_vec(), exp[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [16:0] exp [0:3];
        exp = '{E_FETCH_RDY, E_DECODE_ILL, E_FETCH_WAIT, E_FETCH_WAIT};
        op = 6'b111111; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            memready = (i < 2) ? 1'b1 : 1'b0; #1;
            checks++;
            if (ctrl_vec() !== exp[i]) $display("FAIL illegal cycle %0d: got %b expected %b", i, ctrl_vec(), exp[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_memrd();
        logic [16:0] exp [0:4];
        exp = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD};
        op = 6'b100011; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            memready = (i < 3) ? 1'b1 : 1'b0; #1;
            checks++;
            if (ctrl_vec() !== exp[i]) $display("FAIL rst_memrd cycle %0d: got %b expected %b", i, ctrl_vec(), exp[i]);
            else passed++;
            @(posedge clk); #1;
        end
        reset = 1'b1; memready = 1'b1; #1;
        checks++;
        if (strobes() !== 6'b0) $display("FAIL rst_memrd_strobes: got %b expected %b", strobes(), 6'b0);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0; memready = 1'b0; #1;
        checks++;
        if (ctrl_vec() !== E_FETCH_WAIT) $display("FAIL rst_memrd_fetch: got %b expected %b", ctrl_vec(), E_FETCH_WAIT);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (ctrl_vec() !== E_FETCH_WAIT) $display("FAIL rst_memrd_hold: got %b expected %b", ctrl_vec(), E_FETCH_WAIT);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch(6'b000100, 1'b1, E_BR_TAKEN, "beq_z1");
        test_branch(6'b000100, 1'b0, E_BR_NOT,   "beq_z0");
        test_branch(6'b000101, 1'b1, E_BR_NOT,   "bne_z1");
        test_branch(6'b000101, 1'b0, E_BR_TAKEN, "bne_z0");
        test_branch(6'b000010, 1'b0, E_JEX,      "jump");
        test_rtype();
        test_addi_fetch_wait();
        test_illegal();
        test_reset_in_memrd();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
